// File: rtl/mc_control_unit_hs_if.sv
// Instruction/data memory handshake bundle between the control unit and memory.
interface mc_control_unit_hs_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic            imem_ready;
    logic            ir_we;
    logic            dmem_req;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_we;
    logic [1:0]      dmem_size;
    logic            dmem_sign;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_addr, dmem_we, dmem_size, dmem_sign,
        input  imem_ready, dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_addr, dmem_we, dmem_size, dmem_sign,
        output imem_ready, dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mc_control_unit_hs.sv
// Multi-cycle RV32I control unit: FSM, PC, handshaked memory ports, traps, instret.
module mc_control_unit_hs #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     MEM_TIMEOUT = 255,
    parameter int unsigned     CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [XLEN-1:0]      i_alu_result,
    input  logic                 i_branch_taken,
    mc_control_unit_hs_if.master bus,
    output logic [XLEN-1:0]      o_pc,
    output logic                 o_reg_we,
    output logic [XLEN-1:0]      o_reg_wb_data,
    output logic                 o_alu_src_a,
    output logic                 o_alu_src_b,
    output logic                 o_trap,
    output logic [1:0]           o_trap_cause,
    output logic [XLEN-1:0]      o_trap_pc,
    output logic [CNT_WIDTH-1:0] o_instret
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int unsigned WAIT_W = 10;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_pc_plus4;
    logic [XLEN-1:0]       r_br_target;
    logic [XLEN-1:0]       r_target;
    logic [XLEN-1:0]       r_alu_q;
    logic [XLEN-1:0]       r_mdr;
    logic [CNT_WIDTH-1:0]  r_instret;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_trap;
    logic [1:0]            r_trap_cause;
    logic [XLEN-1:0]       r_trap_pc;

    logic [XLEN-1:0]       w_pc_next;
    logic                  w_retire;
    logic [1:0]            w_cause;
    logic                  w_imem_req;
    logic                  w_ir_we;
    logic                  w_dmem_req;
    logic                  w_reg_we;
    logic                  w_src_a;
    logic                  w_src_b;

    // Opcode classification of the externally latched instruction
    logic w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic w_is_load, w_is_store, w_is_opimm, w_is_op, w_legal;
    assign w_is_lui    = (i_opcode == OPC_LUI);
    assign w_is_auipc  = (i_opcode == OPC_AUIPC);
    assign w_is_jal    = (i_opcode == OPC_JAL);
    assign w_is_jalr   = (i_opcode == OPC_JALR);
    assign w_is_branch = (i_opcode == OPC_BRANCH);
    assign w_is_load   = (i_opcode == OPC_LOAD);
    assign w_is_store  = (i_opcode == OPC_STORE);
    assign w_is_opimm  = (i_opcode == OPC_OPIMM);
    assign w_is_op     = (i_opcode == OPC_OP);
    assign w_legal     = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                         w_is_load | w_is_store | w_is_opimm | w_is_op;

    // Control-flow target and alignment checks evaluated in EXECUTE
    logic            w_jump;
    logic [XLEN-1:0] w_target;
    logic            w_tgt_misal;
    logic [1:0]      w_size;
    logic            w_sign;
    logic            w_data_misal;
    logic            w_wait_limit;
    assign w_jump       = w_is_jal | w_is_jalr | (w_is_branch & i_branch_taken);
    assign w_target     = w_is_jalr ? {i_alu_result[XLEN-1:1], 1'b0} : r_br_target;
    assign w_tgt_misal  = w_jump & w_target[1];
    assign w_size       = i_funct3[1:0];
    assign w_sign       = w_is_store | ~i_funct3[2];
    assign w_data_misal = ((w_size == 2'b01) & i_alu_result[0]) |
                          (w_size[1] & (|i_alu_result[1:0]));
    assign w_wait_limit = (r_wait == WAIT_LIMIT);

    // Next-state, PC update, retire and strobe decode
    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_retire   = 1'b0;
        w_cause    = 2'd0;
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_reg_we   = 1'b0;
        w_src_a    = 1'b0;
        w_src_b    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_wait_limit) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd3;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_next  = S_TRAP;
                    w_cause = 2'd0;
                end
            end
            S_EXECUTE: begin
                w_src_a = w_is_auipc | w_is_jal | w_is_branch;
                w_src_b = ~(w_is_op | w_is_branch);
                if (w_tgt_misal) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd1;
                end else if (w_is_branch) begin
                    w_pc_next = w_jump ? w_target : r_pc_plus4;
                    w_retire  = 1'b1;
                    w_next    = S_FETCH;
                end else if (w_is_load | w_is_store) begin
                    if (w_data_misal) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd2;
                    end else begin
                        w_next = S_MEMORY;
                    end
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                w_dmem_req = 1'b1;
                if (bus.dmem_ready) begin
                    if (w_is_store) begin
                        w_pc_next = r_pc_plus4;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (w_wait_limit) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd3;
                end
            end
            S_WRITEBACK: begin
                w_reg_we  = 1'b1;
                w_pc_next = (w_is_jal | w_is_jalr) ? r_target : r_pc_plus4;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // State register, handshake wait counter and trap capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'd0;
            r_trap_pc    <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if ((r_state == S_FETCH && !bus.imem_ready) ||
                         (r_state == S_MEMORY && !bus.dmem_ready)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_cause;
                r_trap_pc    <= r_pc;
            end
        end
    end

    // PC, retired count and per-instruction datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_pc_plus4  <= '0;
            r_br_target <= '0;
            r_target    <= '0;
            r_alu_q     <= '0;
            r_mdr       <= '0;
            r_instret   <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
            if (r_state == S_DECODE) begin
                r_pc_plus4  <= r_pc + XLEN'(4);
                r_br_target <= r_pc + i_imm;
            end
            if (r_state == S_EXECUTE) begin
                r_alu_q  <= i_alu_result;
                r_target <= w_target;
            end
            if (r_state == S_MEMORY && bus.dmem_ready && w_is_load) begin
                r_mdr <= bus.dmem_rdata;
            end
        end
    end

    // Write-back source select, only driven while writing back
    always_comb begin
        o_reg_wb_data = '0;
        if (r_state == S_WRITEBACK) begin
            if (w_is_load) begin
                o_reg_wb_data = r_mdr;
            end else if (w_is_jal | w_is_jalr) begin
                o_reg_wb_data = r_pc_plus4;
            end else if (w_is_lui) begin
                o_reg_wb_data = i_imm;
            end else begin
                o_reg_wb_data = r_alu_q;
            end
        end
    end

    // Reset forces the state to FETCH, so requests are also gated by rst_n
    // to keep every strobe low while reset is held.
    assign bus.imem_req  = w_imem_req & rst_n;
    assign bus.ir_we     = w_ir_we & rst_n;
    assign bus.dmem_req  = w_dmem_req & rst_n;
    assign bus.dmem_addr = r_alu_q;
    assign bus.dmem_we   = w_dmem_req & rst_n & w_is_store;
    assign bus.dmem_size = (w_dmem_req & rst_n) ? w_size : 2'b00;
    assign bus.dmem_sign = w_dmem_req & rst_n & w_sign;

    assign o_pc         = r_pc;
    assign o_reg_we     = w_reg_we & rst_n;
    assign o_alu_src_a  = w_src_a;
    assign o_alu_src_b  = w_src_b;
    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;
    assign o_trap_pc    = r_trap_pc;
    assign o_instret    = r_instret;

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Directed self-checking bench for mc_control_unit_hs.
module tb_mc_control_unit_hs;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_result;
    logic            branch_taken;
    logic [XLEN-1:0] pc;
    logic            reg_we;
    logic [XLEN-1:0] reg_wb_data;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            trap;
    logic [1:0]      trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [31:0]     instret;

    int n_checks = 0;
    int n_errors = 0;

    mc_control_unit_hs_if #(.XLEN(XLEN)) bus ();

    mc_control_unit_hs #(
        .XLEN        (XLEN),
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (4),
        .CNT_WIDTH   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_opcode       (opcode),
        .i_funct3       (funct3),
        .i_imm          (imm),
        .i_alu_result   (alu_result),
        .i_branch_taken (branch_taken),
        .bus            (bus),
        .o_pc           (pc),
        .o_reg_we       (reg_we),
        .o_reg_wb_data  (reg_wb_data),
        .o_alu_src_a    (alu_src_a),
        .o_alu_src_b    (alu_src_b),
        .o_trap         (trap),
        .o_trap_cause   (trap_cause),
        .o_trap_pc      (trap_pc),
        .o_instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] im,
                         input logic [31:0] alu, input logic tk);
        opcode       = op;
        funct3       = f3;
        imm          = im;
        alu_result   = alu;
        branch_taken = tk;
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: assert reset for one cycle, release at the next negedge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        issue(OPC_OPIMM, 3'b000, 32'd5, 32'd5, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_dmem_req", bus.dmem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", {trap, trap_cause}, 0);
        chk("rst_trap_pc", trap_pc, 0);

        // ADDI x1,x0,5
        cyc(2);
        bus.imem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("addi_c0_imem_req", bus.imem_req, 1);
        chk("addi_c0_ir_we", bus.ir_we, 1);
        cyc(1);
        chk("addi_c1_imem_req", bus.imem_req, 0);
        cyc(1);
        chk("addi_c2_src", {alu_src_a, alu_src_b}, 2'b01);
        chk("addi_c2_reg_we", reg_we, 0);
        cyc(1);
        chk("addi_c3_reg_we", reg_we, 1);
        chk("addi_c3_wb", reg_wb_data, 5);
        cyc(1);
        chk("addi_c4_reg_we", reg_we, 0);
        chk("addi_pc", pc, 32'h4);
        chk("addi_instret", instret, 1);

        // LW 0x100 with ready on the 4th request cycle (also the timeout limit cycle)
        issue(OPC_LOAD, 3'b010, 32'h100, 32'h100, 1'b0);
        cyc(2);
        chk("lw_exec_no_req", bus.dmem_req, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("lw_req", bus.dmem_req, 1);
            chk("lw_addr", bus.dmem_addr, 32'h100);
            chk("lw_we_size", {bus.dmem_we, bus.dmem_size}, 3'b010);
            if (k == 3) begin
                bus.dmem_ready = 1'b1;
                bus.dmem_rdata = 32'hDEAD_BEEF;
            end
        end
        cyc(1);
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        chk("lw_wb_reg_we", reg_we, 1);
        chk("lw_wb_data", reg_wb_data, 32'hDEAD_BEEF);
        chk("lw_wb_req_low", bus.dmem_req, 0);
        chk("lw_no_trap", trap, 0);
        cyc(1);
        chk("lw_pc", pc, 32'h8);
        chk("lw_instret", instret, 2);

        // Two ADDIs to reach pc 0x10
        issue(OPC_OPIMM, 3'b000, 32'd1, 32'd1, 1'b0);
        cyc(8);
        chk("addi2_pc", pc, 32'h10);
        chk("addi2_instret", instret, 4);

        // JAL imm 8 at 0x10
        issue(OPC_JAL, 3'b000, 32'h8, 32'h0, 1'b0);
        cyc(2);
        chk("jal_src", {alu_src_a, alu_src_b}, 2'b11);
        cyc(1);
        chk("jal_reg_we", reg_we, 1);
        chk("jal_wb", reg_wb_data, 32'h14);
        cyc(1);
        chk("jal_pc", pc, 32'h18);
        chk("jal_instret", instret, 5);

        // JAL 0x18 -> 0x20
        cyc(4);
        chk("jal2_pc", pc, 32'h20);

        // BEQ taken imm -16 at 0x20
        issue(OPC_BRANCH, 3'b000, 32'hFFFF_FFF0, 32'h0, 1'b1);
        cyc(2);
        chk("beq_src", {alu_src_a, alu_src_b}, 2'b10);
        chk("beq_reg_we", reg_we, 0);
        cyc(1);
        chk("beq_t_pc", pc, 32'h10);
        chk("beq_t_instret", instret, 7);

        // JAL 0x10 -> 0x20, then BEQ not taken
        issue(OPC_JAL, 3'b000, 32'h10, 32'h0, 1'b0);
        cyc(4);
        chk("jal3_pc", pc, 32'h20);
        issue(OPC_BRANCH, 3'b000, 32'hFFFF_FFF0, 32'h0, 1'b0);
        cyc(3);
        chk("beq_nt_pc", pc, 32'h24);
        chk("beq_nt_instret", instret, 9);

        // LH at 0x101: misaligned data
        issue(OPC_LOAD, 3'b001, 32'h101, 32'h101, 1'b0);
        cyc(2);
        chk("lh_exec_no_req", bus.dmem_req, 0);
        cyc(1);
        chk("lh_trap", {trap, trap_cause}, 3'b110);
        chk("lh_trap_pc", trap_pc, 32'h24);
        chk("lh_no_req", {bus.imem_req, bus.dmem_req}, 0);
        cyc(3);
        chk("lh_hold_trap", trap, 1);
        chk("lh_hold_pc", pc, 32'h24);
        chk("lh_hold_instret", instret, 9);
        chk("lh_hold_req", {bus.imem_req, bus.dmem_req, reg_we}, 0);

        // Illegal opcode after reset
        rst_n = 1'b0;
        #1;
        chk("rst2_trap", trap, 0);
        chk("rst2_pc", pc, 0);
        cyc(1);
        issue(7'b1111111, 3'b000, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        cyc(2);
        chk("ill_trap", {trap, trap_cause}, 3'b100);
        chk("ill_trap_pc", trap_pc, 0);
        chk("ill_reg_we", reg_we, 0);

        // SW with ready on the 4th cycle: no trap, retires
        issue(OPC_STORE, 3'b010, 32'h40, 32'h40, 1'b0);
        pulse_reset();
        cyc(2);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("sw_req", {bus.dmem_req, bus.dmem_we, bus.dmem_sign}, 3'b111);
            if (k == 3) bus.dmem_ready = 1'b1;
        end
        cyc(1);
        bus.dmem_ready = 1'b0;
        chk("sw_pc", pc, 32'h4);
        chk("sw_instret", instret, 1);
        chk("sw_no_trap", trap, 0);
        chk("sw_req_low", bus.dmem_req, 0);

        // LW with dmem_ready held low: timeout after 4 cycles
        issue(OPC_LOAD, 3'b010, 32'h200, 32'h200, 1'b0);
        cyc(2);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("to_req", bus.dmem_req, 1);
        end
        cyc(1);
        chk("to_req_drop", bus.dmem_req, 0);
        chk("to_trap", {trap, trap_cause}, 3'b111);
        chk("to_trap_pc", trap_pc, 32'h4);
        chk("to_instret", instret, 1);

        // ADDI then LBU; reset asserted mid-MEMORY
        issue(OPC_OPIMM, 3'b000, 32'd7, 32'd7, 1'b0);
        pulse_reset();
        cyc(4);
        chk("mr_pc", pc, 32'h4);
        issue(OPC_LOAD, 3'b100, 32'h33, 32'h33, 1'b0);
        cyc(3);
        chk("mr_lbu_req", {bus.dmem_req, bus.dmem_size, bus.dmem_sign}, 4'b1000);
        chk("mr_lbu_addr", bus.dmem_addr, 32'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_drop", {bus.dmem_req, bus.imem_req, reg_we}, 0);
        chk("mr_pc_rst", pc, 0);
        chk("mr_instret_rst", instret, 0);
        chk("mr_addr_rst", bus.dmem_addr, 0);
        chk("mr_trap_rst", {trap, trap_cause}, 0);
        cyc(1);
        rst_n = 1'b1;
        #1;
        chk("mr_restart_req", bus.imem_req, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit_hs.md
Name: mc_control_unit_hs

Overview:
Parametrised multi-cycle RV32I control unit with an integrated state machine, PC register and valid/ready handshakes on the instruction and data memory ports. It replaces fixed-latency memory timing with stall-tolerant handshakes. It also adds trap detection for illegal opcodes, misalignment and bus timeout, plus a retired-instruction counter. It sits between the decoder/regfile/ALU datapath and the memory subsystem of the multi-cycle core.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 255, max cycles a memory request may wait for ready before a bus-error trap (1..1023)
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  decoded opcode of the latched instruction
funct3  in  3  funct3 of the latched instruction
imm  in  XLEN  sign-extended immediate
alu_result  in  XLEN  ALU output (valid in EXECUTE)
branch_taken  in  1  comparator result for the current branch (valid in EXECUTE)
imem_req  out  1  instruction fetch request, address = pc
imem_ready  in  1  fetch complete; the instruction is latched externally on ir_we
ir_we  out  1  instruction register load strobe
dmem_req  out  1  data access request, address = alu_result captured in EXECUTE (dmem_addr)
dmem_addr  out  XLEN  data address
dmem_we  out  1  store when 1, load when 0
dmem_size  out  2  00 byte, 01 half, 10 word
dmem_sign  out  1  load sign-extend
dmem_ready  in  1  data access complete
dmem_rdata  in  XLEN  load data, valid when dmem_ready
pc  out  XLEN  current PC
reg_we  out  1  register-file write strobe
reg_wb_data  out  XLEN  write-back value
alu_src_a  out  1  0 = rs1, 1 = pc
alu_src_b  out  1  0 = rs2, 1 = imm
trap  out  1  core halted on a trap
trap_cause  out  2  0 illegal, 1 misaligned target, 2 misaligned data, 3 bus timeout
trap_pc  out  XLEN  PC of the faulting instruction
instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH, pc = RESET_PC, instret = 0, trap = 0, trap_cause = 0, trap_pc = 0, all strobes and requests = 0, internal MDR/address/target registers = 0.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH:
  - imem_req = 1 and held until imem_ready.
  - On the imem_ready cycle: ir_we = 1 and the next state is DECODE.
- DECODE:
  - An opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} goes to TRAP with cause 0.
  - Otherwise the next state is EXECUTE.
  - pc_plus4 = pc + 4 and br_target = pc + imm are registered here, both with modulo-2^XLEN wrap.
- EXECUTE:
  - alu_src_a = 1 for AUIPC, JAL and BRANCH; alu_src_b = 1 for all types except OP and BRANCH.
  - alu_result is captured into the address/result register.
  - Jump target: JAL uses br_target; JALR uses {alu_result[XLEN-1:1], 0}; a taken BRANCH uses br_target.
  - If the target has bit[1] set, go to TRAP with cause 1.
  - BRANCH: pc <= taken ? target : pc_plus4, retire, then FETCH.
  - LOAD/STORE: check alignment (half needs addr[0] = 0; word needs addr[1:0] = 0). A violation goes to TRAP with cause 2; otherwise go to MEMORY.
  - All other opcodes go to WRITEBACK.
- MEMORY:
  - dmem_req = 1, held with stable addr/we/size/sign until dmem_ready.
  - LOAD: dmem_rdata is latched into the MDR on ready, then WRITEBACK.
  - STORE: pc <= pc_plus4, retire, then FETCH.
- WRITEBACK:
  - reg_we = 1 for exactly one cycle. JAL/JALR then pc <= target; all others pc <= pc_plus4.
  - Retire, then FETCH.
- reg_wb_data:
  - LOAD: MDR.
  - JAL/JALR: pc_plus4.
  - LUI: imm.
  - Otherwise: the captured ALU result.
- Retire: instret increments by 1 and wraps at 2^CNT_WIDTH.
- dmem_size/dmem_sign decode from funct3: 000 b/s, 001 h/s, 010 w, 100 b/u, 101 h/u. dmem_sign = 1 for stores.
- Timeout:
  - A wait counter clears on entry to FETCH and on entry to MEMORY, and increments each cycle the request is unanswered.
  - When it reaches MEMORY_TIMEOUT with ready still low, the request drops and the next state is TRAP with cause 3.
  - A ready arriving in the same cycle as the limit wins; no trap is raised.
- TRAP:
  - trap = 1, trap_pc = pc of the faulting instruction.
  - No requests, no reg_we; pc and instret are frozen.
  - Only rst_n exits this state.
- Nominal latency with ready returned in the same cycle:
  - Branch 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR and store 4 cycles.
  - Load 5 cycles.
- Reset asserted mid-MEMORY: the request drops immediately, with no retire and no reg_we.

Test Plan:
- Reset release, imem_ready tied 1, ADDI x1,x0,5 → imem_req in cycle 0; reg_we in cycle 3 with reg_wb_data 5; pc 0→4; instret 1.
- LW at addr 0x100, dmem_ready delayed 3 cycles, rdata 0xDEADBEEF → dmem_req high for 4 cycles with stable addr; reg_wb_data 0xDEADBEEF; 8 cycles total.
- JAL imm 8 at pc 0x10 → reg_wb_data 0x14, pc 0x18. BEQ taken imm −16 at pc 0x20 → pc 0x10. BEQ not taken → pc 0x24.
- LH at addr 0x101 → trap = 1, cause 2, trap_pc = instruction pc, no dmem_req. Opcode 7'b1111111 → cause 0.
- MEMORY_TIMEOUT = 4, dmem_ready held 0 → dmem_req drops after 4 cycles, cause 3. Repeat with ready on the 4th cycle → no trap.
- rst_n pulsed low mid-MEMORY → all outputs reset asynchronously; pc = RESET_PC; instret = 0.
